// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared types for the LC-3 memory arbiter slice
package lc3_pkg;

  localparam int LC3_ADDR_W = 16;
  localparam int LC3_DATA_W = 16;

  typedef logic [LC3_ADDR_W-1:0] addr_t;
  typedef logic [LC3_DATA_W-1:0] word_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LD  = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/lc3_mem_arbiter_if.sv
// rtl/lc3_mem_arbiter_if.sv - one requester's request/response channel into the arbiter
interface lc3_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/lc3_rr_arb2.sv
// rtl/lc3_rr_arb2.sv - two-way round-robin grant with loader priority override
module lc3_rr_arb2
  import lc3_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  logic   req_cpu,
  input  logic   req_ld,
  input  logic   hold,
  output logic   gnt_cpu,
  output logic   gnt_ld,
  output owner_e last_gnt
);

  always_comb begin
    gnt_cpu = 1'b0;
    gnt_ld  = 1'b0;
    if (en) begin
      if (hold && req_ld) begin
        gnt_ld = 1'b1;
      end else if (req_cpu && !req_ld) begin
        gnt_cpu = 1'b1;
      end else if (req_ld && !req_cpu) begin
        gnt_ld = 1'b1;
      end else if (req_cpu && req_ld) begin
        // Tie goes to whoever was not served last.
        if (last_gnt == OWN_LD) begin
          gnt_cpu = 1'b1;
        end else begin
          gnt_ld = 1'b1;
        end
      end
    end
  end

  // A grant is only issued to a valid requester, so every grant is an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= OWN_LD;
    end else if (gnt_cpu) begin
      last_gnt <= OWN_CPU;
    end else if (gnt_ld) begin
      last_gnt <= OWN_LD;
    end
  end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// rtl/lc3_mem_arbiter.sv - single-transaction arbiter sharing LC-3 memory between CPU and loader
module lc3_mem_arbiter
  import lc3_pkg::*;
#(
  parameter int ADDR_W  = LC3_ADDR_W,
  parameter int DATA_W  = LC3_DATA_W,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  lc3_mem_arbiter_if.slave  cpu,
  lc3_mem_arbiter_if.slave  ld,
  input  logic              ld_hold,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  generate
    if (MEM_LAT < 1) begin : g_lat_check
      $fatal(1, "lc3_mem_arbiter: MEM_LAT must be >= 1");
    end
  endgenerate

  arb_state_e        state_q;
  arb_state_e        state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic              gnt_cpu;
  logic              gnt_ld;
  logic              accept;
  owner_e            last_gnt;

  lc3_rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state_q == ARB_IDLE),
    .req_cpu  (cpu.req_valid),
    .req_ld   (ld.req_valid),
    .hold     (ld_hold),
    .gnt_cpu  (gnt_cpu),
    .gnt_ld   (gnt_ld),
    .last_gnt (last_gnt)
  );

  assign accept = gnt_cpu | gnt_ld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:  if (accept) state_d = ARB_ISSUE;
      ARB_ISSUE: state_d = (MEM_LAT == 1) ? ARB_RESP : ARB_WAIT;
      ARB_WAIT:  if (cnt_q == CNT_ONE) state_d = ARB_RESP;
      ARB_RESP:  state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  // Request fields are latched at accept so requesters may change them while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cnt_q     <= '0;
    end else begin
      if (accept) begin
        cap_we    <= gnt_ld ? ld.req_we    : cpu.req_we;
        cap_addr  <= gnt_ld ? ld.req_addr  : cpu.req_addr;
        cap_wdata <= gnt_ld ? ld.req_wdata : cpu.req_wdata;
      end
      if (state_q == ARB_ISSUE) begin
        cnt_q <= CNT_LOAD;
      end else if (state_q == ARB_WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_ONE;
      end
    end
  end

  always_comb begin
    cpu.req_ready = gnt_cpu;
    ld.req_ready  = gnt_ld;
    mem_en        = (state_q == ARB_ISSUE);
    mem_we        = (state_q == ARB_ISSUE) && cap_we;
    mem_addr      = cap_addr;
    mem_wdata     = cap_wdata;
    busy          = (state_q != ARB_IDLE);
    owner         = (last_gnt == OWN_LD);
    cpu.rsp_valid = (state_q == ARB_RESP) && (last_gnt == OWN_CPU);
    ld.rsp_valid  = (state_q == ARB_RESP) && (last_gnt == OWN_LD);
    // The memory's own output register supplies the data in RESP; writes return zero.
    cpu.rsp_rdata = (cpu.rsp_valid && !cap_we) ? mem_rdata : '0;
    ld.rsp_rdata  = (ld.rsp_valid && !cap_we) ? mem_rdata : '0;
  end

endmodule
